// File: rtl/axis2difftest_unpack.sv
// Rebuilds DATA_WIDTH-bit difftest packets from an LSB-first AXI-Stream of
// 8-packet bursts, checking headers and tlast placement with sticky error flags.
module axis2difftest_unpack #(
   parameter int DATA_WIDTH             = 16000,
   parameter int AXIS_DATA_WIDTH        = 512,
   parameter int NUM_PACKETS_PER_BUFFER = 8
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic [AXIS_DATA_WIDTH-1:0] axi_tdata,
   input  logic [63:0]                axi_tkeep,
   input  logic                       axi_tlast,
   input  logic                       axi_tvalid,
   output logic                       axi_tready,
   output logic [DATA_WIDTH-1:0]      out_data,
   output logic [7:0]                 out_seq,
   output logic                       out_first,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       err_seq,
   output logic                       err_hdr,
   output logic                       err_last,
   output logic                       state_dbg
);

   // Handshakes: a beat moves when axi_tvalid && axi_tready, a packet moves
   // when out_valid && out_ready; both are sampled on the rising clock edge.

   localparam int BEATS = (DATA_WIDTH + 8 + AXIS_DATA_WIDTH - 1) / AXIS_DATA_WIDTH;
   localparam int BCW   = $clog2(BEATS) + 1;
   localparam int ASW   = BEATS * AXIS_DATA_WIDTH;
   localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
   localparam logic [7:0]     LAST_PKT  = 8'(NUM_PACKETS_PER_BUFFER - 1);

   typedef enum logic {RECV = 1'b0, HOLD = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [BCW-1:0]   beat_cnt;
   logic [7:0]       pkt_cnt;
   logic [7:0]       exp_seq;
   logic [ASW-1:0]   asm_q, asm_next;
   logic [7:0]       hdr;
   logic             beat_acc, last_beat, deliver, drop;
   logic             unused_ok;

   assign state_dbg = state_q;
   assign unused_ok = &{1'b0, axi_tkeep, asm_next};

   // The assembly image including the beat currently on the bus, so the last
   // beat can be delivered on the same edge it is accepted.
   always_comb begin
      asm_next = asm_q;
      for (int i = 0; i < BEATS; i++) begin
         if (beat_cnt == BCW'(i)) asm_next[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] = axi_tdata;
      end
   end

   assign hdr = asm_next[7:0];

   always_comb begin
      state_d   = state_q;
      beat_acc  = axi_tvalid & axi_tready;
      last_beat = (beat_cnt == LAST_BEAT);
      deliver   = beat_acc & last_beat;
      drop      = beat_acc & axi_tlast & ~last_beat;
      case (state_q)
         RECV: if (deliver) state_d = HOLD;
         HOLD: if (out_valid && out_ready) state_d = RECV;
         default: state_d = RECV;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= RECV;
         axi_tready <= 1'b0;
         beat_cnt   <= '0;
         pkt_cnt    <= '0;
         exp_seq    <= '0;
         asm_q      <= '0;
         out_data   <= '0;
         out_seq    <= '0;
         out_first  <= 1'b0;
         out_valid  <= 1'b0;
         err_seq    <= 1'b0;
         err_hdr    <= 1'b0;
         err_last   <= 1'b0;
      end else begin
         state_q    <= state_d;
         axi_tready <= (state_d == RECV);
         if (state_q == HOLD && out_valid && out_ready) out_valid <= 1'b0;
         if (drop) begin
            // tlast mid-packet: discard the partial packet and restart the burst.
            beat_cnt <= '0;
            pkt_cnt  <= '0;
            err_last <= 1'b1;
         end else if (beat_acc) begin
            asm_q <= asm_next;
            if (last_beat) begin
               beat_cnt  <= '0;
               out_data  <= asm_next[DATA_WIDTH+7:8];
               out_first <= (pkt_cnt == 8'd0);
               out_valid <= 1'b1;
               if (pkt_cnt == 8'd0) begin
                  out_seq <= hdr;
                  exp_seq <= hdr + 8'd1;
                  if (hdr != exp_seq) err_seq <= 1'b1;
               end else if (hdr != 8'd0) begin
                  err_hdr <= 1'b1;
               end
               if (axi_tlast) begin
                  pkt_cnt <= '0;
                  if (pkt_cnt != LAST_PKT) err_last <= 1'b1;
               end else if (pkt_cnt == LAST_PKT) begin
                  pkt_cnt  <= '0;
                  err_last <= 1'b1;
               end else begin
                  pkt_cnt <= pkt_cnt + 8'd1;
               end
            end else begin
               beat_cnt <= beat_cnt + BCW'(1);
            end
         end
      end
   end

endmodule
